fp16_mult_result_queue: RTL and testbench

- Registered result stage directly downstream of the combinational half-precision multiplier.
- Captures each product together with its two source operands and computes IEEE exception flags from them.
- Buffers the results in a DEPTH-entry FIFO and hands them to the writeback/accumulate consumer over a valid/ready handshake.
- Decouples the multiplier's combinational path from consumer backpressure.

---
 rtl/fpu_types_pkg.sv | 23 ++
 rtl/fp16_classify.sv | 28 ++
 rtl/fp16_mult_result_queue.sv | 126 ++++++++++++
 tb/tb_fp16_mult_result_queue.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_types_pkg.sv
// Shared half-precision FPU types: exponent limit, exception flag layout and operand classes.
package fpu_types_pkg;

    localparam logic [4:0] HALF_EXP_MAX = 5'h1F;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fp_flags_t;

    typedef enum logic [2:0] {
        ZERO,
        SUB,
        NORM,
        INF,
        QNAN,
        SNAN
    } half_class_t;

endpackage

// File: rtl/fp16_classify.sv
// Combinational IEEE half-precision classifier: zero, subnormal, normal, infinity, quiet or signalling NaN.
module fp16_classify
    import fpu_types_pkg::*;
(
    input  logic [15:0]  value,
    output half_class_t  cls
);

    logic [4:0] exp_field;
    logic [9:0] man_field;

    assign exp_field = value[14:10];
    assign man_field = value[9:0];

    always_comb begin
        cls = NORM;
        if (exp_field == 5'd0) begin
            cls = (man_field == 10'd0) ? ZERO : SUB;
        end else if (exp_field == HALF_EXP_MAX) begin
            if (man_field == 10'd0) begin
                cls = INF;
            end else begin
                cls = man_field[9] ? QNAN : SNAN;
            end
        end
    end

endmodule

// File: rtl/fp16_mult_result_queue.sv
// Result FIFO behind the fp16 multiplier: stores {product, flags, tag} and computes IEEE flags at push.
// Optional sticky flag accumulator (fflags/fflags_clr) is built when FPU_STICKY_FLAGS_EN is defined.
module fp16_mult_result_queue
    import fpu_types_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [15:0]               in_float1,
    input  logic [15:0]               in_float2,
    input  logic [15:0]               in_product,
    input  logic [TAG_W-1:0]          in_tag,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [15:0]               out_product,
    output logic [4:0]                out_flags,
    output logic [TAG_W-1:0]          out_tag,
    output logic [$clog2(DEPTH):0]    count
`ifdef FPU_STICKY_FLAGS_EN
    ,
    output logic [4:0]                fflags,
    input  logic                      fflags_clr
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Valid/ready: a transfer happens on a rising edge where both valid and ready are high;
    // in_ready reflects only occupancy, so a full queue never accepts while popping.
    logic push;
    logic pop;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [15:0]      mem_product [DEPTH];
    fp_flags_t        mem_flags   [DEPTH];
    logic [TAG_W-1:0] mem_tag     [DEPTH];

    half_class_t cls1;
    half_class_t cls2;
    half_class_t cls_p;
    fp_flags_t   new_flags;

    fp16_classify u_cls1 (.value(in_float1),  .cls(cls1));
    fp16_classify u_cls2 (.value(in_float2),  .cls(cls2));
    fp16_classify u_clsp (.value(in_product), .cls(cls_p));

    logic op1_special;
    logic op2_special;

    assign op1_special = (cls1 == INF) || (cls1 == QNAN) || (cls1 == SNAN);
    assign op2_special = (cls2 == INF) || (cls2 == QNAN) || (cls2 == SNAN);

    always_comb begin
        new_flags    = '0;
        new_flags.nv = (cls1 == SNAN) || (cls2 == SNAN) ||
                       ((cls1 == ZERO) && (cls2 == INF)) ||
                       ((cls1 == INF) && (cls2 == ZERO));
        new_flags.dz = 1'b0;
        new_flags.of = (cls_p == INF) && !op1_special && !op2_special;
        new_flags.uf = ((cls_p == ZERO) || (cls_p == SUB)) &&
                       (cls1 != ZERO) && (cls2 != ZERO) && !op1_special && !op2_special;
        new_flags.nx = new_flags.of || new_flags.uf;
    end

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_product = mem_product[rd_ptr];
    assign out_flags   = mem_flags[rd_ptr];
    assign out_tag     = mem_tag[rd_ptr];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_product[i] <= '0;
                mem_flags[i]   <= '0;
                mem_tag[i]     <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_product[wr_ptr] <= in_product;
                mem_flags[wr_ptr]   <= new_flags;
                mem_tag[wr_ptr]     <= in_tag;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

`ifdef FPU_STICKY_FLAGS_EN
    // A clear in the same cycle as a pop leaves exactly the popped entry's flags.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fflags <= '0;
        end else if (fflags_clr) begin
            fflags <= (pop && !flush) ? out_flags : 5'd0;
        end else if (pop && !flush) begin
            fflags <= fflags | out_flags;
        end
    end
`endif

endmodule

// File: tb/tb_fp16_mult_result_queue.sv
// Self-checking bench for fp16_mult_result_queue: directed cases plus random traffic against a queue model.
module tb_fp16_mult_result_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic        CLK;
    logic        nRST;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_float1;
    logic [15:0] in_float2;
    logic [15:0] in_product;
    logic [3:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_product;
    logic [4:0]  out_flags;
    logic [3:0]  out_tag;
    logic [2:0]  count;
`ifdef FPU_STICKY_FLAGS_EN
    logic [4:0]  fflags;
`endif
    logic        fflags_clr;

    fp16_mult_result_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .CLK(CLK),
        .nRST(nRST),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_float1(in_float1),
        .in_float2(in_float2),
        .in_product(in_product),
        .in_tag(in_tag),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_product(out_product),
        .out_flags(out_flags),
        .out_tag(out_tag),
        .count(count)
`ifdef FPU_STICKY_FLAGS_EN
        ,
        .fflags(fflags),
        .fflags_clr(fflags_clr)
`endif
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // scoreboard: {product[15:0], flags[4:0], tag[3:0]}
    logic [24:0] exp_q[$];
    logic [4:0]  exp_ff = 5'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference flag rules from the IEEE classes, computed on plain field values.
    function automatic logic [4:0] model_flags(input logic [15:0] a, input logic [15:0] b,
                                               input logic [15:0] p);
        int ea, ma, eb, mb, ep, mp;
        bit a_zero, b_zero, a_inf, b_inf, a_snan, b_snan, p_inf, nv, of, uf;
        ea = (a >> 10) & 31; ma = a & 1023;
        eb = (b >> 10) & 31; mb = b & 1023;
        ep = (p >> 10) & 31; mp = p & 1023;
        a_zero = (ea == 0) && (ma == 0);
        b_zero = (eb == 0) && (mb == 0);
        a_inf  = (ea == 31) && (ma == 0);
        b_inf  = (eb == 31) && (mb == 0);
        a_snan = (ea == 31) && (ma != 0) && (ma < 512);
        b_snan = (eb == 31) && (mb != 0) && (mb < 512);
        p_inf  = (ep == 31) && (mp == 0);
        nv = a_snan || b_snan || (a_zero && b_inf) || (a_inf && b_zero);
        of = p_inf && (ea != 31) && (eb != 31);
        uf = (ep == 0) && !a_zero && !b_zero && (ea != 31) && (eb != 31);
        return {nv, 1'b0, of, uf, of || uf};
    endfunction

    task automatic check_outputs();
        logic [24:0] head;
        check("count", 32'(count), 32'(exp_q.size()));
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            check("out_product", 32'(out_product), 32'(head[24:9]));
            check("out_flags", 32'(out_flags), 32'(head[8:4]));
            check("out_tag", 32'(out_tag), 32'(head[3:0]));
        end
`ifdef FPU_STICKY_FLAGS_EN
        check("fflags", 32'(fflags), 32'(exp_ff));
`endif
    endtask

    // driver: called at a negedge, checks current state, drives one cycle, returns at next negedge
    task automatic step(input logic v, input logic [15:0] f1, input logic [15:0] f2,
                        input logic [15:0] p, input logic [3:0] t, input logic r,
                        input logic fl, input logic clr);
        bit do_push, do_pop;
        logic [24:0] popped;
        check_outputs();
        in_valid   = v;
        in_float1  = f1;
        in_float2  = f2;
        in_product = p;
        in_tag     = t;
        out_ready  = r;
        flush      = fl;
        fflags_clr = clr;
        do_push = v && (exp_q.size() != DEPTH);
        do_pop  = r && (exp_q.size() != 0);
        popped  = '0;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (do_pop) popped = exp_q.pop_front();
            if (do_push) exp_q.push_back({p, model_flags(f1, f2, p), t});
        end
        if (clr) exp_ff = 5'd0;
        if (do_pop && !fl) exp_ff = exp_ff | popped[8:4];
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle(input logic r);
        step(1'b0, 16'h0, 16'h0, 16'h0, 4'h0, r, 1'b0, 1'b0);
    endtask

    task automatic directed(input logic [15:0] f1, input logic [15:0] f2, input logic [15:0] p,
                            input logic [3:0] t, input logic [4:0] flags_exp);
        step(1'b1, f1, f2, p, t, 1'b0, 1'b0, 1'b0);
        check("dir_valid", 32'(out_valid), 32'd1);
        check("dir_product", 32'(out_product), 32'(p));
        check("dir_flags", 32'(out_flags), 32'(flags_exp));
        check("dir_tag", 32'(out_tag), 32'(t));
        idle(1'b1);
    endtask

    function automatic logic [15:0] rand_half();
        logic [15:0] s;
        s = 16'($urandom_range(0, 1) << 15);
        case ($urandom_range(0, 7))
            0: return s;
            1: return s | 16'h7C00;
            2: return s | 16'h7E00 | 16'($urandom_range(0, 511));
            3: return s | 16'h7C00 | 16'($urandom_range(1, 511));
            4: return s | 16'($urandom_range(1, 1023));
            default: return 16'($urandom_range(0, 65535));
        endcase
    endfunction

    initial begin
        nRST = 1'b0; in_valid = 0; in_float1 = 0; in_float2 = 0; in_product = 0;
        in_tag = 0; flush = 0; out_ready = 0; fflags_clr = 0;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_product", 32'(out_product), 32'd0);
        check("rst_flags", 32'(out_flags), 32'd0);
        check("rst_tag", 32'(out_tag), 32'd0);
        nRST = 1'b1;
        @(negedge CLK);

        // exception flag cases
        directed(16'h3C00, 16'h4000, 16'h4000, 4'd3, 5'b00000);
        directed(16'h7BFF, 16'h7BFF, 16'h7C00, 4'd4, 5'b00101);
        directed(16'h7C00, 16'h3C00, 16'h7C00, 4'd5, 5'b00000);
        directed(16'h7C01, 16'h3C00, 16'hFFFF, 4'd6, 5'b10000);
        directed(16'h8000, 16'h7C00, 16'hFFFF, 4'd7, 5'b10000);
        directed(16'h7E00, 16'h3C00, 16'h7E00, 4'd8, 5'b00000);
        directed(16'h0400, 16'h3800, 16'h0200, 4'd9, 5'b00011);

        // backpressure, full queue, wrap
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 16'h3C00, 16'h3C00, 16'h3C00 + 16'(i), 4'(i), 1'b0, 1'b0, 1'b0);
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        step(1'b1, 16'h3C00, 16'h3C00, 16'h1234, 4'hF, 1'b0, 1'b0, 1'b0);
        check("full_ignore_count", 32'(count), 32'd4);
        step(1'b1, 16'h3C00, 16'h3C00, 16'h2222, 4'hA, 1'b1, 1'b0, 1'b0);
        check("pop_only_count", 32'(count), 32'd3);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 16'h4000, 16'h3C00, 16'h4100 + 16'(i), 4'(i + 2), 1'b1, 1'b0, 1'b0);
            check("pushpop_count", 32'(count), 32'd3);
        end
        for (int i = 0; i < 3; i++) idle(1'b1);

        // flush drops queue and the concurrent input
        step(1'b1, 16'h3C00, 16'h3C00, 16'h3C00, 4'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h3C00, 16'h3C00, 16'h3C00, 4'd2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h3C00, 16'h3C00, 16'h3C00, 4'd3, 1'b1, 1'b1, 1'b0);
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);

        // asynchronous reset mid-cycle
        step(1'b1, 16'h7BFF, 16'h7BFF, 16'h7C00, 4'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h4000, 16'h4000, 16'h4400, 4'd2, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 nRST = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_product", 32'(out_product), 32'd0);
        check("arst_flags", 32'(out_flags), 32'd0);
        check("arst_tag", 32'(out_tag), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        exp_ff = 5'd0;
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);

`ifdef FPU_STICKY_FLAGS_EN
        step(1'b0, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h7BFF, 16'h7BFF, 16'h7C00, 4'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h7C01, 16'h3C00, 16'hFFFF, 4'd2, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        check("sticky_or", 32'(fflags), 32'b10101);
        step(1'b1, 16'h0400, 16'h3800, 16'h0200, 4'd3, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b1);
        check("sticky_clr_pop", 32'(fflags), 32'b00011);
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [15:0] a, b;
            a = rand_half();
            b = rand_half();
            step(1'($urandom_range(0, 99) < 60), a, b, rand_half(), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 3),
                 1'($urandom_range(0, 99) < 5));
        end
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
